// File: rtl/guineveer_mem_bank.sv
// Single-port byte-strobed memory bank (req/gnt/rvalid) with fixed read latency and range check.
// Define GUINEVEER_MEM_STALL_EN to withhold grants pseudo-randomly from a 16-bit LFSR.
module guineveer_mem_bank #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned LATENCY    = 1,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(NBYTES);
  localparam int unsigned WIDX_W = ADDR_WIDTH - OFF_W;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDX_W:0] DEPTH_L = (WIDX_W + 1)'(DEPTH);

  logic              accept;
  logic              in_range;
  logic [WIDX_W-1:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;

  // The full word index is range-checked so high addresses never alias low words.
  assign word_idx = addr_i[ADDR_WIDTH-1:OFF_W];
  assign in_range = ({1'b0, word_idx} < DEPTH_L);
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign accept   = req_i && gnt_o;

  if (OFF_W > 0) begin : g_offset
    logic addr_offset_unused;
    assign addr_offset_unused = ^addr_i[OFF_W-1:0];
  end

`ifdef GUINEVEER_MEM_STALL_EN
  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;

  // Fibonacci form, taps 16,14,13,11 map to bits 0,2,3,5 when shifting toward bit 0.
  assign lfsr_next = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_reg <= STALL_SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign gnt_o = rst_ni && (lfsr_reg[1:0] != 2'b00);
`else
  logic [15:0] stall_seed_unused;
  assign stall_seed_unused = STALL_SEED;
  assign gnt_o = rst_ni;
`endif

  // Storage plus data pipeline; data_reg[0] is the read-first RAM output register.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_reg [LATENCY];

  always_ff @(posedge clk_i) begin
    if (accept && in_range) begin
      data_reg[0] <= mem[mem_idx];
      for (int b = 0; b < NBYTES; b++) begin
        if (we_i && strb_i[b]) begin
          mem[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    for (int s = 1; s < LATENCY; s++) begin
      data_reg[s] <= data_reg[s-1];
    end
  end

  logic [LATENCY-1:0] valid_reg;
  logic [LATENCY-1:0] valid_next;
  logic [LATENCY-1:0] err_reg;
  logic [LATENCY-1:0] err_next;

  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign valid_next[gi] = accept;
      assign err_next[gi]   = accept && !in_range;
    end else begin : g_shift
      assign valid_next[gi] = valid_reg[gi-1];
      assign err_next[gi]   = err_reg[gi-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_reg <= '0;
      err_reg   <= '0;
    end else begin
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  // Data registers are never reset; the output mask keeps rdata_o zero unless a good response is valid.
  assign rvalid_o = valid_reg[LATENCY-1];
  assign err_o    = err_reg[LATENCY-1];
  assign rdata_o  = (rvalid_o && !err_o) ? data_reg[LATENCY-1] : '0;

endmodule

// File: tb/tb_guineveer_mem_bank.sv
// Bench for guineveer_mem_bank: directed vector table, reset/latency sequences and randomized traffic
// checked against a cycle-scheduled reference model.
module tb_guineveer_mem_bank;

  localparam int LAT   = 3;
  localparam int DEPTH = 4096;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [63:0] wdata_i;
  logic [7:0]  strb_i;
  logic        rvalid_o;
  logic [63:0] rdata_o;
  logic        err_o;

  guineveer_mem_bank #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(64),
    .DEPTH     (DEPTH),
    .LATENCY   (LAT),
    .STALL_SEED(16'hACE1)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .gnt_o   (gnt_o),
    .addr_i  (addr_i),
    .we_i    (we_i),
    .wdata_i (wdata_i),
    .strb_i  (strb_i),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
    logic        known;
  } rsp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  int n_acc  = 0;
  int n_rsp  = 0;
  bit init_phase = 1'b0;

  logic [63:0] ref_mem [int unsigned];
  rsp_t        exp_at [int];
  rsp_t        got_q [$];
  int          rv_cyc_q [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, ncyc);
    end
  endtask

  // Reference model: each accept schedules its response LAT samples later; memory is a plain word map.
  initial begin
    rsp_t        e;
    rsp_t        p;
    bit          ev;
    int unsigned widx;
    logic [63:0] nv;
    forever begin
      @(negedge clk_i);
      ev = exp_at.exists(ncyc);
      e  = ev ? exp_at[ncyc] : '0;
      check("rvalid", 64'(rvalid_o), 64'(ev));
      check("err", 64'(err_o), 64'(e.err));
      if (!ev || e.known) check("rdata", rdata_o, e.data);
      if (ev) exp_at.delete(ncyc);
      if (rvalid_o) begin
        n_rsp++;
        rv_cyc_q.push_back(ncyc);
        got_q.push_back('{data: rdata_o, err: err_o, known: 1'b1});
      end
`ifdef GUINEVEER_MEM_STALL_EN
      if (!rst_ni) check("gnt_in_reset", 64'(gnt_o), 64'(0));
`else
      check("gnt", 64'(gnt_o), 64'(rst_ni));
`endif
      if (!rst_ni) begin
        n_acc -= exp_at.num();
        exp_at.delete();
      end else if (req_i && gnt_o) begin
        widx    = addr_i >> 3;
        p.known = !init_phase;
        if (widx >= DEPTH) begin
          p.data  = '0;
          p.err   = 1'b1;
          p.known = 1'b1;
        end else begin
          p.err  = 1'b0;
          p.data = ref_mem.exists(widx) ? ref_mem[widx] : '0;
          if (we_i) begin
            nv = p.data;
            for (int b = 0; b < 8; b++) if (strb_i[b]) nv[8*b +: 8] = wdata_i[8*b +: 8];
            ref_mem[widx] = nv;
          end
        end
        exp_at[ncyc + LAT] = p;
        n_acc++;
      end
      ncyc++;
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [63:0] wd, input logic [7:0] st);
    int n = 0;
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd; strb_i = st;
    while (!gnt_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("grant_wait", 64'(gnt_o), 64'(1));
    @(posedge clk_i); #1;
    req_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs [16];
  int   stalls;
  int   a0;
  int   seen;
  int   t0;
  bit   prev_acc;
  int   sel;

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0000, 64'h1122334455667788, 8'hFF, 64'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0000, 64'h0, 8'h00, 64'h1122334455667788, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0008, 64'h0, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0008, 64'h0, 8'h00, 64'hFFFF_FFFF_0000_0000, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_8000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 64'h0, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_8000, 64'h0, 8'h00, 64'h0, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0000, 64'h0, 8'h00, 64'h1122334455667788, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0004, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00, 64'h1122334455667788, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0007, 64'h0, 8'h00, 64'h1122334455667788, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_7FF8, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_7FF8, 64'h0, 8'h00, 64'h0123456789ABCDEF, 1'b0};
    vecs[12] = '{1'b0, 32'h0010_0000, 64'h0, 8'h00, 64'h0, 1'b1};
    vecs[13] = '{1'b1, 32'h0000_0010, 64'hA5A5_A5A5_A5A5_A5A5, 8'h81, 64'h0, 1'b0};
    vecs[14] = '{1'b0, 32'h0000_0010, 64'h0, 8'h00, 64'hA500_0000_0000_00A5, 1'b0};
    vecs[15] = '{1'b0, 32'hFFFF_FFF8, 64'h0, 8'h00, 64'h0, 1'b1};

    rst_ni = 1'b0; req_i = 1'b1; we_i = 1'b1; addr_i = '0; wdata_i = '1; strb_i = '1;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_rvalid", 64'(rvalid_o), 64'(0));
    check("reset_rdata", rdata_o, 64'(0));
    check("reset_err", 64'(err_o), 64'(0));
    check("reset_gnt", 64'(gnt_o), 64'(0));
    req_i = 1'b0;
    rst_ni = 1'b1;

    // Known contents for every word the rest of the run touches.
    init_phase = 1'b1;
    for (int w = 0; w < 16; w++) issue(1'b1, 32'(w * 8), 64'h0, 8'hFF);
    issue(1'b1, 32'h0000_7FF8, 64'h0, 8'hFF);
    init_phase = 1'b0;
    idle(LAT + 2);

    got_q.delete();
    foreach (vecs[i]) issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
    idle(LAT + 2);
    check("table_rsp_count", 64'(got_q.size()), 64'(16));
    foreach (vecs[i]) begin
      if (i < got_q.size()) begin
        $display("vec %0d we=%0b addr=%h strb=%h -> rdata=%h err=%0b (want %h/%0b)", i, vecs[i].we,
                 vecs[i].addr, vecs[i].strb, got_q[i].data, got_q[i].err, vecs[i].exp_data, vecs[i].exp_err);
        check($sformatf("tbl%0d_data", i), got_q[i].data, vecs[i].exp_data);
        check($sformatf("tbl%0d_err", i), 64'(got_q[i].err), 64'(vecs[i].exp_err));
      end
    end

    // Four back-to-back reads: responses on four consecutive cycles, LAT after the first accept.
    rv_cyc_q.delete();
    got_q.delete();
    t0 = ncyc;
    for (int k = 0; k < 4; k++) issue(1'b0, 32'(k * 8), 64'h0, 8'h00);
    idle(LAT + 2);
    check("b2b_count", 64'(rv_cyc_q.size()), 64'(4));
`ifndef GUINEVEER_MEM_STALL_EN
    foreach (rv_cyc_q[k]) check($sformatf("b2b_cycle%0d", k), 64'(rv_cyc_q[k]), 64'(t0 + LAT + k));
`endif
    if (got_q.size() >= 4) begin
      check("b2b_data0", got_q[0].data, 64'h1122334455667788);
      check("b2b_data1", got_q[1].data, 64'hFFFF_FFFF_0000_0000);
      check("b2b_data2", got_q[2].data, 64'hA500_0000_0000_00A5);
    end

    // Two reads in flight, then a one-cycle reset: both responses must vanish.
    issue(1'b0, 32'h0, 64'h0, 8'h00);
    issue(1'b0, 32'h8, 64'h0, 8'h00);
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    seen = 0;
    repeat (LAT + 3) begin
      @(negedge clk_i);
      if (rvalid_o) seen++;
    end
    check("flush_rvalid_count", 64'(seen), 64'(0));
    @(posedge clk_i); #1;
    got_q.delete();
    issue(1'b0, 32'h0, 64'h0, 8'h00);
    idle(LAT + 2);
    check("post_reset_count", 64'(got_q.size()), 64'(1));
    if (got_q.size() == 1) check("post_reset_data", got_q[0].data, 64'h1122334455667788);

    // Request held for 1000 cycles: grant-low share and accept accounting.
    stalls = 0;
    a0 = n_acc;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h8;
    for (int i = 0; i < 1000; i++) begin
      if (!gnt_o) stalls++;
      @(posedge clk_i); #1;
    end
    req_i = 1'b0;
    check("held_accepts", 64'(n_acc - a0), 64'(1000 - stalls));
`ifdef GUINEVEER_MEM_STALL_EN
    check("stall_share_in_20_30pct", 64'(stalls >= 200 && stalls <= 300), 64'(1));
`else
    check("stall_count", 64'(stalls), 64'(0));
`endif
    idle(LAT + 2);

    // Randomized traffic with occasional resets; payload held while not granted.
    prev_acc = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!req_i || prev_acc) begin
        req_i   = ($urandom_range(3) != 0);
        we_i    = 1'($urandom_range(1));
        sel     = $urandom_range(9);
        if (sel == 0)      addr_i = 32'h0000_8000 + 32'($urandom_range(255) * 8);
        else if (sel == 1) addr_i = $urandom | 32'h0010_0000;
        else               addr_i = 32'($urandom_range(15) * 8 + $urandom_range(7));
        wdata_i = {$urandom, $urandom};
        strb_i  = 8'($urandom_range(255));
      end
      rst_ni = ($urandom_range(199) != 0);
      @(negedge clk_i);
      prev_acc = req_i && gnt_o;
      @(posedge clk_i); #1;
    end
    rst_ni = 1'b1;
    req_i  = 1'b0;
    idle(LAT + 3);
    check("rsp_vs_accept_count", 64'(n_rsp), 64'(n_acc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
